// File: rtl/rename_pkg.sv
// rename_pkg: shared sizes, index types and renamed-instruction record for the rename stage
package rename_pkg;
  localparam int NUM_AREGS = 32;
  localparam int NUM_PREGS = 64;
  localparam int AREG_W = 5;
  localparam int PREG_W = 6;
  localparam int FL_DEPTH = NUM_PREGS - NUM_AREGS;
  localparam int FL_W = 5;
  typedef logic [AREG_W-1:0] areg_t;
  typedef logic [PREG_W-1:0] preg_t;
  typedef struct packed {
    preg_t prs1;
    preg_t prs2;
    preg_t prd;
    preg_t old_prd;
    logic rd_wen;
  } renamed_instr_t;
endpackage

// File: rtl/rename_free_list.sv
// rename_free_list: circular FIFO of free physical registers, preloaded with p32..p63 on reset
// ports: clk, rst_n (sync active-low), pop (caller guarantees count!=0), push/push_preg,
//        head_preg (entry popped next), count (entries held)
module rename_free_list import rename_pkg::*; (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pop,
  input  logic              push,
  input  logic [PREG_W-1:0] push_preg,
  output logic [PREG_W-1:0] head_preg,
  output logic [PREG_W:0]   count
);
  preg_t fifo [FL_DEPTH];
  logic [FL_W-1:0] head, tail;
  // p0 is the hardwired x0 mapping and never re-enters the pool; a full pool drops the push
  logic push_ok;
  assign push_ok = push && push_preg != '0 && count != (PREG_W+1)'(FL_DEPTH);
  assign head_preg = fifo[head];
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < FL_DEPTH; i++) fifo[i] <= PREG_W'(NUM_AREGS + i);
      head <= '0;
      tail <= '0;
      count <= (PREG_W+1)'(FL_DEPTH);
    end else begin
      if (push_ok) begin
        fifo[tail] <= push_preg;
        tail <= tail + FL_W'(1);
      end
      if (pop) head <= head + FL_W'(1);
      count <= count + (PREG_W+1)'(push_ok) - (PREG_W+1)'(pop);
    end
  end
endmodule

// File: rtl/rename_stage.sv
// rename_stage: maps rs1/rs2 through the RAT, allocates a fresh preg for rd, registers the result
// ports: clk, rst_n (sync active-low); in_* decode handshake and arch regs; out_* registered
//        renamed instruction with valid/ready; free_valid/free_preg commit return; free_count.
// optional: RENAME_STATS_EN adds stat_renamed and stat_stall_nofree saturating counters.
module rename_stage import rename_pkg::*; (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [AREG_W-1:0] in_rs1,
  input  logic [AREG_W-1:0] in_rs2,
  input  logic [AREG_W-1:0] in_rd,
  input  logic              in_rd_wen,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PREG_W-1:0] out_prs1,
  output logic [PREG_W-1:0] out_prs2,
  output logic [PREG_W-1:0] out_prd,
  output logic [PREG_W-1:0] out_old_prd,
  output logic              out_rd_wen,
  input  logic              free_valid,
  input  logic [PREG_W-1:0] free_preg,
`ifdef RENAME_STATS_EN
  output logic [31:0]       stat_renamed,
  output logic [31:0]       stat_stall_nofree,
`endif
  output logic [PREG_W:0]   free_count
);
  preg_t rat [NUM_AREGS];
  renamed_instr_t out_q;
  preg_t head_preg;
  logic need_alloc, accept;
  assign need_alloc = in_rd_wen && in_rd != '0;
  assign in_ready = (!out_valid || out_ready) && (!need_alloc || free_count != '0);
  assign accept = in_valid && in_ready;
  assign {out_prs1, out_prs2, out_prd, out_old_prd, out_rd_wen} = out_q;
  rename_free_list u_fl (
    .clk(clk), .rst_n(rst_n), .pop(accept && need_alloc), .push(free_valid),
    .push_preg(free_preg), .head_preg(head_preg), .count(free_count)
  );
  // RAT[0] is never written (need_alloc excludes rd==x0), so x0 stays on p0
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_AREGS; i++) rat[i] <= PREG_W'(i);
      out_valid <= 1'b0;
      out_q <= '0;
    end else begin
      if (accept) begin
        out_q <= '{prs1: rat[in_rs1], prs2: rat[in_rs2],
                   prd: need_alloc ? head_preg : '0,
                   old_prd: need_alloc ? rat[in_rd] : '0,
                   rd_wen: need_alloc};
        if (need_alloc) rat[in_rd] <= head_preg;
      end
      out_valid <= accept || (out_valid && !out_ready);
    end
  end
`ifdef RENAME_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_renamed <= '0;
      stat_stall_nofree <= '0;
    end else begin
      if (accept && stat_renamed != '1) stat_renamed <= stat_renamed + 32'd1;
      if (in_valid && need_alloc && free_count == '0 && stat_stall_nofree != '1)
        stat_stall_nofree <= stat_stall_nofree + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_rename_stage.sv
// tb_rename_stage: directed vector table plus hand sequences for pool exhaustion and recovery
module tb_rename_stage;
  import rename_pkg::*;
  logic clk = 1'b0;
  logic rst_n, in_valid, in_ready, in_rd_wen, out_valid, out_ready, out_rd_wen, free_valid;
  logic [AREG_W-1:0] in_rs1, in_rs2, in_rd;
  logic [PREG_W-1:0] out_prs1, out_prs2, out_prd, out_old_prd, free_preg;
  logic [PREG_W:0] free_count;
`ifdef RENAME_STATS_EN
  logic [31:0] stat_renamed, stat_stall_nofree;
`endif
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  rename_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_rd_wen(in_rd_wen),
    .out_valid(out_valid), .out_ready(out_ready), .out_prs1(out_prs1), .out_prs2(out_prs2),
    .out_prd(out_prd), .out_old_prd(out_old_prd), .out_rd_wen(out_rd_wen),
    .free_valid(free_valid), .free_preg(free_preg),
`ifdef RENAME_STATS_EN
    .stat_renamed(stat_renamed), .stat_stall_nofree(stat_stall_nofree),
`endif
    .free_count(free_count)
  );
  typedef struct {
    logic r, v; int rs1, rs2, rd; logic wen, ordy, fv; int fp;
    logic irdy, ov; int p1, p2, pd, po; logic ow; int fc;
  } vec_t;
  vec_t vecs [20];
  function automatic vec_t mk(input logic r, v, input int rs1, rs2, rd, input logic wen, ordy, fv,
                              input int fp, input logic irdy, ov, input int p1, p2, pd, po,
                              input logic ow, input int fc);
    mk = '{r, v, rs1, rs2, rd, wen, ordy, fv, fp, irdy, ov, p1, p2, pd, po, ow, fc};
  endfunction
  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask
  initial begin
    //           r v rs1 rs2 rd wen rdy fv fp | irdy ov p1 p2 pd po ow fc
    vecs[0]  = mk(1,0, 0, 0, 0,0,1,0, 0, 1,0, 0, 0, 0, 0,0,32);
    vecs[1]  = mk(1,1, 1, 2, 3,1,1,0, 0, 1,1, 1, 2,32, 3,1,31);
    vecs[2]  = mk(1,1, 3, 3, 3,1,1,0, 0, 1,1,32,32,33,32,1,30);
    vecs[3]  = mk(1,1, 3, 4, 7,0,1,0, 0, 1,1,33, 4, 0, 0,0,30);
    vecs[4]  = mk(1,1, 1, 0, 0,1,1,0, 0, 1,1, 1, 0, 0, 0,0,30);
    vecs[5]  = mk(1,0, 0, 0, 0,0,1,0, 0, 1,0, 0, 0, 0, 0,0,30);
    vecs[6]  = mk(1,1, 3, 1, 4,1,0,0, 0, 1,1,33, 1,34, 4,1,29);
    vecs[7]  = mk(1,1, 4, 4, 5,1,0,0, 0, 0,1,33, 1,34, 4,1,29);
    vecs[8]  = mk(1,1, 4, 4, 5,1,0,0, 0, 0,1,33, 1,34, 4,1,29);
    vecs[9]  = mk(1,1, 4, 4, 5,1,0,0, 0, 0,1,33, 1,34, 4,1,29);
    vecs[10] = mk(1,1, 4, 4, 5,1,1,0, 0, 1,1,34,34,35, 5,1,28);
    vecs[11] = mk(1,0, 0, 0, 0,0,1,0, 0, 1,0, 0, 0, 0, 0,0,28);
    vecs[12] = mk(1,0, 0, 0, 0,0,1,1, 0, 1,0, 0, 0, 0, 0,0,28);
    vecs[13] = mk(1,0, 0, 0, 0,0,1,1, 9, 1,0, 0, 0, 0, 0,0,29);
    vecs[14] = mk(0,1, 1, 2, 6,1,1,1,10, 1,0, 0, 0, 0, 0,0,32);
    vecs[15] = mk(1,1, 3,31, 5,1,1,0, 0, 1,1, 3,31,32, 5,1,31);
    vecs[16] = mk(1,0, 0, 0, 0,0,1,1,12, 1,0, 0, 0, 0, 0,0,32);
    vecs[17] = mk(1,0, 0, 0, 0,0,1,1,13, 1,0, 0, 0, 0, 0,0,32);
    vecs[18] = mk(1,1, 5, 0, 6,1,1,0, 0, 1,1,32, 0,33, 6,1,31);
    vecs[19] = mk(1,1, 6, 5, 7,1,1,1,15, 1,1,33,32,34, 7,1,31);
    rst_n = 1'b0; in_valid = 1'b0; in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_rd_wen = 1'b0;
    out_ready = 1'b1; free_valid = 1'b0; free_preg = '0;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      rst_n = vecs[i].r; in_valid = vecs[i].v; in_rs1 = AREG_W'(vecs[i].rs1);
      in_rs2 = AREG_W'(vecs[i].rs2); in_rd = AREG_W'(vecs[i].rd); in_rd_wen = vecs[i].wen;
      out_ready = vecs[i].ordy; free_valid = vecs[i].fv; free_preg = PREG_W'(vecs[i].fp);
      #1 check($sformatf("vec%0d in_ready", i), 64'(in_ready), 64'(vecs[i].irdy));
      @(posedge clk);
      #1;
      if (vecs[i].ov)
        check($sformatf("vec%0d outputs", i),
              64'({out_valid, out_prs1, out_prs2, out_prd, out_old_prd, out_rd_wen, free_count}),
              64'({1'b1, PREG_W'(vecs[i].p1), PREG_W'(vecs[i].p2), PREG_W'(vecs[i].pd),
                   PREG_W'(vecs[i].po), vecs[i].ow, (PREG_W+1)'(vecs[i].fc)}));
      else
        check($sformatf("vec%0d idle", i), 64'({out_valid, free_count}),
              64'({1'b0, (PREG_W+1)'(vecs[i].fc)}));
    end
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0; free_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      in_valid = 1'b1; in_rs1 = '0; in_rs2 = '0; in_rd_wen = 1'b1; in_rd = AREG_W'((k % 31) + 1);
      @(posedge clk);
      #1 check($sformatf("drain%0d prd", k), 64'({out_valid, out_prd}), 64'({1'b1, PREG_W'(32 + k)}));
    end
    check("drain wrap old_prd", 64'(out_old_prd), 64'd32);
    check("empty count", 64'(free_count), 64'd0);
    @(negedge clk);
    in_rd = 5'd2; free_valid = 1'b1; free_preg = 6'd3;
    #1 check("empty in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1 check("no bypass", 64'({out_valid, free_count}), 64'({1'b0, 7'd1}));
    @(negedge clk);
    free_valid = 1'b0;
    #1 check("refill in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1 check("refill alloc", 64'({out_valid, out_prd, out_old_prd, free_count}),
             64'({1'b1, 6'd3, 6'd33, 7'd0}));
    @(negedge clk);
    in_valid = 1'b0; free_valid = 1'b1; free_preg = '0;
    @(posedge clk);
    #1 check("p0 free ignored", 64'(free_count), 64'd0);
    @(negedge clk);
    free_valid = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rename_stage.md
Name: rename_stage

Overview:
- Register-rename stage of the out-of-order RISC-V core, directly downstream of decode.
- Accepts one decoded instruction per cycle as architectural rs1/rs2/rd.
- Maps the sources through the RAT and allocates a fresh physical register for rd from the free pool.
- Presents the renamed instruction on a registered valid/ready output to the next stage (dispatch).
- Commit returns freed physical registers through a separate port.

Parameters:
- NUM_AREGS, 32, number of architectural registers (x0..x31).
- NUM_PREGS, 64, number of physical registers (p0..p63).
- AREG_W, 5, architectural index width (log2 NUM_AREGS).
- PREG_W, 6, physical index width (log2 NUM_PREGS).

Ports:
- clk  in  1  core clock, all state on rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on rising clk.
- in_valid  in  1  decode presents an instruction.
- in_ready  out  1  rename accepts this cycle.
- in_rs1  in  AREG_W  source 1 arch reg.
- in_rs2  in  AREG_W  source 2 arch reg.
- in_rd  in  AREG_W  destination arch reg.
- in_rd_wen  in  1  instruction writes rd (0 for SW).
- out_valid  out  1  renamed instruction valid.
- out_ready  in  1  downstream accepts.
- out_prs1  out  PREG_W  physical source 1.
- out_prs2  out  PREG_W  physical source 2.
- out_prd  out  PREG_W  newly allocated physical dest.
- out_old_prd  out  PREG_W  previous mapping of rd, freed later at commit.
- out_rd_wen  out  1  registered copy of in_rd_wen, forced 0 when rd==x0.
- free_valid  in  1  commit returns a physical register.
- free_preg  in  PREG_W  register being returned.
- free_count  out  PREG_W+1  entries currently in the free pool.

Behaviour:
- Reset (rst_n=0 at clk edge):
  - RAT[i]=p_i for every i.
  - Free pool is a circular FIFO holding p32..p63 in order; head=0, tail=0, free_count=32.
  - out_valid=0; out_prs1, out_prs2, out_prd, out_old_prd=0; out_rd_wen=0.
  - Reset mid-operation discards any held output and any in-flight accept or free that cycle.
- Allocation:
  - need_alloc = in_rd_wen && in_rd!=0.
  - in_ready = (!out_valid || out_ready) && (!need_alloc || free_count!=0). It is combinational on the in_* signals.
- Accept when in_valid && in_ready. Latency is 1 cycle; outputs register on the accepting edge:
  - out_prs1=RAT[in_rs1] and out_prs2=RAT[in_rs2], both read before this instruction's RAT update. So rs1==rd reads the old mapping.
  - If need_alloc: out_prd = FIFO[head]; out_old_prd = RAT[in_rd]; RAT[in_rd] <= FIFO[head]; head++ with wrap at NUM_PREGS-NUM_AREGS.
  - Else: out_prd=0, out_old_prd=0, no pop.
  - x0 always maps to p0; RAT[0] is never written.
- Hold: out_valid=1 && out_ready=0 keeps all out_* stable.
- out_valid clears when out_ready=1 and there is no new accept.
- Back-to-back accepts: the second instruction sees the first one's RAT update, since the update is registered on the accept edge.
- Free port, when free_valid=1:
  - FIFO[tail] <= free_preg; tail++ with wrap.
  - A freed register becomes allocatable the next cycle only; no same-cycle bypass when the pool is empty.
- Ignored frees (no state change):
  - free_preg==0.
  - free_valid while free_count==NUM_PREGS-NUM_AREGS.
- Simultaneous pop and push: free_count is unchanged.

Optional Feature:
- Macro: RENAME_STATS_EN.
- When defined:
  - Adds outputs stat_renamed (32, count of accepts) and stat_stall_nofree (32, cycles with in_valid && need_alloc && free_count==0).
  - Both counters reset to 0 and saturate at all-ones.
- When undefined: these ports and counters do not exist, and behaviour is otherwise identical.

Decomposition:
- Shared package rename_pkg holds:
  - NUM_AREGS, NUM_PREGS, AREG_W, PREG_W;
  - typedefs areg_t and preg_t;
  - struct renamed_instr_t {prs1, prs2, prd, old_prd, rd_wen}.
- One sub-module: rename_free_list (circular FIFO with push/pop/count and reset preload of p32..p63).
- The RAT stays inline in rename_stage.

Test Plan:
- Reset, then accept ADD x3,x1,x2 (rd_wen=1) -> next cycle out_valid=1, prs1=1, prs2=2, prd=32, old_prd=3, free_count=31.
- Accept ADD x3,x3,x3 immediately after -> prs1=prs2=32, prd=33, old_prd=32; RAT[3]=33.
- Accept SW (rd_wen=0) and ADDI x0,x1,5 -> prd=0, out_rd_wen=0, free_count unchanged.
- 32 allocating accepts with out_ready=1 -> free_count=0, in_ready=0 for the 33rd. Then assert free_valid with preg 3 -> in_ready=1 the following cycle, and the 33rd gets prd=3.
- Hold out_ready=0 for 3 cycles after an accept -> out_* stable and in_ready=0; RAT and free_count unchanged by the held input.
- Mid-stream rst_n=0 for one edge with in_valid=1 and free_valid=1 -> out_valid=0, free_count=32, RAT[i]=p_i; the next accept of rd=x5 gets prd=32, old_prd=5.
